dose_scheduler: RTL
===================

Name: dose_scheduler

Overview:
- Holds a small table of medicine dose slots, each with a med ID and a repeat interval in Tick units.
- Counts each slot down and raises a single user-facing alarm for due doses, serving them round-robin.
- Handles acknowledge, snooze and timeout/missed-dose outcomes.
- Sits between the time base (Tick generator), the button conditioner and the display/buzzer path. Slots are programmed by the ROM browse/select path.

Parameters:
- NUM_SLOTS, 4, number of dose slots (power of 2, 2..8).
- ID_W, 4, med ID width; the all-ones ID is the stop word.
- CNT_W, 12, interval/countdown width in Ticks.
- SNOOZE_TICKS, 5, Ticks spent in snooze before re-alarm.
- ALARM_TIMEOUT, 30, Ticks of unanswered alarm before the dose is declared missed.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-low.
- Enable  in  1  block enable; 0 freezes the block and forces idle outputs.
- Tick  in  1  one-cycle time-base pulse.
- Prog_Valid  in  1  one-cycle slot write strobe.
- Prog_Slot  in  clog2(NUM_SLOTS)  slot index to write.
- Prog_MedID  in  ID_W  med ID (stop word = clear slot).
- Prog_Interval  in  CNT_W  repeat interval; 0 = clear slot.
- AckButton  in  1  one-cycle pulse from the button conditioner.
- SnoozeButton  in  1  one-cycle pulse from the button conditioner.
- Alarm  out  1  alarm active (buzzer/LED).
- Alarm_Slot  out  clog2(NUM_SLOTS)  slot being alarmed or snoozed.
- Alarm_MedID  out  ID_W  med ID of that slot; all-ones when idle.
- Snoozed  out  1  FSM is in SNOOZE.
- Missed  out  1  one-cycle pulse per missed dose.
- Missed_Count  out  8  saturating count of missed doses.
- Pending  out  NUM_SLOTS  per-slot due-but-unserved flags.

Behaviour:
- Reset (Rst=0 at a Clk edge):
  - all slots invalid; countdowns and pending cleared;
  - FSM IDLE; round-robin pointer = NUM_SLOTS-1;
  - Alarm=0, Alarm_Slot=0, Alarm_MedID=all-ones, Snoozed=0, Missed=0, Missed_Count=0, Pending=0.
  - Reset mid-alarm drops Alarm on the next edge.
- Enable=0:
  - FSM forced to IDLE; Alarm=0, Snoozed=0, Alarm_MedID=all-ones;
  - Tick, buttons and Prog ignored;
  - slot table, countdowns and pending are preserved.
- Slot write (Prog_Valid=1):
  - Interval=0 or MedID=stop word: slot becomes invalid and its pending is cleared.
  - Otherwise: valid=1, med_id and interval stored, countdown=interval, pending cleared.
  - Prog wins over a Tick in the same cycle for that slot.
  - Writing the slot currently in ALARM/SNOOZE returns the FSM to IDLE next edge with Alarm=0. No Missed pulse is generated.
- Countdown, on Tick, for each valid slot:
  - countdown>1: decrement.
  - countdown==1: set pending and reload countdown=interval.
  - If pending was already set when the slot comes due again: Missed pulse, Missed_Count+1 (saturates at 255), pending stays 1.
  - Two or more slots missing in the same Tick: Missed pulses once; Missed_Count increments once per slot (saturating).
- FSM states: IDLE, ALARM, SNOOZE.
  - IDLE: if any pending, select the first pending slot searching upward from pointer+1 with wrap, latch it into Alarm_Slot/Alarm_MedID, clear the timeout counter, go to ALARM.
  - ALARM: Alarm=1.
    - AckButton: clear that slot's pending, pointer=slot, go to IDLE.
    - Else SnoozeButton: load snooze counter=SNOOZE_TICKS, go to SNOOZE.
    - Else on Tick: timeout counter+1. On reaching ALARM_TIMEOUT: Missed pulse, Missed_Count+1, clear pending, pointer=slot, go to IDLE.
    - Ack and Snooze in the same cycle: Ack wins.
  - SNOOZE: Alarm=0, Snoozed=1.
    - AckButton: clear pending, go to IDLE.
    - Each Tick decrements the snooze counter; at 0, return to ALARM with the timeout counter cleared.
- Latency: a slot due at the Tick in cycle T shows Pending at T+1 and Alarm at T+2 when the FSM is IDLE. Alarm drops the cycle after the Ack edge.
- Countdown continues for alarmed/snoozed slots; the next due while still pending counts as missed.

Decomposition:
- Package dose_sched_pkg:
  - FSM state encoding;
  - STOP_ID (all-ones);
  - SLOT_W = clog2(NUM_SLOTS);
  - missed-count width constant.
- Sub-module dose_slot: one table entry (valid, med_id, interval, countdown, pending, program/tick/clear logic, due strobe). It is instantiated NUM_SLOTS times by generate. The top level holds the round-robin selector, FSM and counters.

Test Plan:
- Reset with Enable=1 -> Alarm=0, Alarm_MedID=4'hF, Pending=0, Missed_Count=0.
- Program slot 1 (ID 3, interval 2), two Ticks -> Pending=4'b0010 one cycle after 2nd Tick, Alarm=1/Alarm_MedID=3/Alarm_Slot=1 one cycle later; Ack -> Alarm=0 next cycle, Pending=0.
- Slots 0 and 2 due on same Tick -> slot 0 alarmed first; after Ack, slot 2 alarmed; after Ack, Pending=0.
- Alarm on slot 1, Snooze -> Snoozed=1, Alarm=0; 5 Ticks -> Alarm=1 again; Ack and Snooze same cycle -> Ack taken, IDLE.
- Alarm with no response for 30 Ticks -> one Missed pulse, Missed_Count=1, Pending cleared; interval re-due while pending -> Missed_Count=2.
- Program alarmed slot with MedID 4'hF mid-ALARM -> Alarm=0 next edge, slot invalid, no Missed; Enable=0 during countdown -> countdown frozen across Ticks.

Source files
------------

// File: rtl/dose_sched_pkg.sv
// Shared constants for the dose scheduler: FSM encoding, stop word, widths.
package dose_sched_pkg;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int ID_W_DEF      = 4;
    localparam int MISS_W        = 8;

    localparam int SLOT_W = $clog2(NUM_SLOTS_DEF);

    localparam logic [ID_W_DEF-1:0] STOP_ID = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ALARM  = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    function automatic int slot_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/dose_slot.sv
// One dose table entry: programming, countdown, pending flag, due/miss strobes.
module dose_slot #(
    parameter int ID_W  = 4,
    parameter int CNT_W = 12
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic             prog_we_i,
    input  logic [ID_W-1:0]  prog_id_i,
    input  logic [CNT_W-1:0] prog_int_i,
    input  logic             clr_i,
    output logic [ID_W-1:0]  med_id_o,
    output logic             pending_o,
    output logic             miss_o
);

    logic             valid_q, valid_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] int_q, int_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             prog_clr;
    logic             due;
    logic             pend_keep;

    always_comb begin
        prog_clr  = (prog_int_i == '0) || (prog_id_i == {ID_W{1'b1}});
        due       = en_i & tick_i & valid_q & ~prog_we_i
                  & (cnt_q <= CNT_W'(1));
        // an ack landing on the same cycle as a new due is not a miss
        pend_keep = pend_q & ~clr_i;
        miss_o    = due & pend_keep;

        valid_d = valid_q;
        id_d    = id_q;
        int_d   = int_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        if (en_i) begin
            if (prog_we_i) begin
                pend_d = 1'b0;
                if (prog_clr) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    valid_d = 1'b1;
                    id_d    = prog_id_i;
                    int_d   = prog_int_i;
                    cnt_d   = prog_int_i;
                end
            end else begin
                if (tick_i && valid_q)
                    cnt_d = due ? int_q : cnt_q - CNT_W'(1);
                pend_d = pend_keep | due;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            valid_q <= 1'b0;
            id_q    <= '1;
            int_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            int_q   <= int_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign med_id_o  = id_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/dose_scheduler.sv
// Dose slot table with round-robin alarm FSM, snooze and missed-dose tracking.
module dose_scheduler
    import dose_sched_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int ID_W          = 4,
    parameter int CNT_W         = 12,
    parameter int SNOOZE_TICKS  = 5,
    parameter int ALARM_TIMEOUT = 30
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Enable,
    input  logic                         Tick,
    input  logic                         Prog_Valid,
    input  logic [slot_w(NUM_SLOTS)-1:0] Prog_Slot,
    input  logic [ID_W-1:0]              Prog_MedID,
    input  logic [CNT_W-1:0]             Prog_Interval,
    input  logic                         AckButton,
    input  logic                         SnoozeButton,
    output logic                         Alarm,
    output logic [slot_w(NUM_SLOTS)-1:0] Alarm_Slot,
    output logic [ID_W-1:0]              Alarm_MedID,
    output logic                         Snoozed,
    output logic                         Missed,
    output logic [MISS_W-1:0]            Missed_Count,
    output logic [NUM_SLOTS-1:0]         Pending
);

    localparam int SW    = slot_w(NUM_SLOTS);
    localparam int TMO_W = $clog2(ALARM_TIMEOUT + 1);
    localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [SW-1:0]     ptr_q, ptr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [SNZ_W-1:0]  snz_q, snz_d;
    logic              missed_q, missed_d;
    logic [MISS_W-1:0] mcnt_q, mcnt_d;

    logic [NUM_SLOTS-1:0] pend;
    logic [NUM_SLOTS-1:0] slot_miss;
    logic [NUM_SLOTS-1:0] prog_we;
    logic [NUM_SLOTS-1:0] clr_vec;
    logic [NUM_SLOTS-1:0] pend_m;
    logic [ID_W-1:0]      med_id [NUM_SLOTS];

    logic          sel_found;
    logic [SW-1:0] sel_idx;
    logic [SW-1:0] idx;
    logic          timeout;
    logic          prog_hit;
    logic [3:0]    miss_n;
    logic [8:0]    mcnt_sum;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign prog_we[g] = Enable & Prog_Valid & (Prog_Slot == SW'(g));

        dose_slot #(
            .ID_W  (ID_W),
            .CNT_W (CNT_W)
        ) u_slot (
            .Clk        (Clk),
            .Rst        (Rst),
            .en_i       (Enable),
            .tick_i     (Tick),
            .prog_we_i  (prog_we[g]),
            .prog_id_i  (Prog_MedID),
            .prog_int_i (Prog_Interval),
            .clr_i      (clr_vec[g]),
            .med_id_o   (med_id[g]),
            .pending_o  (pend[g]),
            .miss_o     (slot_miss[g])
        );
    end

    // a slot rewritten this cycle loses its pending, so never pick it
    always_comb begin
        pend_m    = pend & ~prog_we;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            idx = ptr_q + SW'(k);
            if (!sel_found && pend_m[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        tmo_d    = tmo_q;
        snz_d    = snz_q;
        clr_vec  = '0;
        timeout  = 1'b0;
        prog_hit = Prog_Valid && (Prog_Slot == slot_q)
                && (state_q != ST_IDLE);

        if (!Enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        state_d = ST_ALARM;
                        slot_d  = sel_idx;
                        id_d    = med_id[sel_idx];
                        tmo_d   = '0;
                    end
                end
                ST_ALARM: begin
                    if (AckButton) begin
                        clr_vec[slot_q] = 1'b1;
                        ptr_d   = slot_q;
                        state_d = ST_IDLE;
                    end else if (SnoozeButton) begin
                        snz_d   = SNZ_W'(SNOOZE_TICKS);
                        state_d = ST_SNOOZE;
                    end else if (Tick) begin
                        if (tmo_q == TMO_W'(ALARM_TIMEOUT - 1)) begin
                            timeout = 1'b1;
                            clr_vec[slot_q] = 1'b1;
                            ptr_d   = slot_q;
                            state_d = ST_IDLE;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (AckButton) begin
                        clr_vec[slot_q] = 1'b1;
                        ptr_d   = slot_q;
                        state_d = ST_IDLE;
                    end else if (Tick) begin
                        if (snz_q <= SNZ_W'(1)) begin
                            snz_d   = '0;
                            tmo_d   = '0;
                            state_d = ST_ALARM;
                        end else begin
                            snz_d = snz_q - SNZ_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (prog_hit) begin
                state_d = ST_IDLE;
                timeout = 1'b0;
                clr_vec = '0;
            end
        end
    end

    always_comb begin
        miss_n = {3'b0, timeout};
        for (int i = 0; i < NUM_SLOTS; i++)
            miss_n = miss_n + {3'b0, slot_miss[i]};
        mcnt_sum = {1'b0, mcnt_q} + {5'b0, miss_n};
        mcnt_d   = (mcnt_sum > 9'd255) ? 8'hFF : mcnt_sum[7:0];
        missed_d = (|slot_miss) | timeout;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            id_q     <= '1;
            ptr_q    <= SW'(NUM_SLOTS - 1);
            tmo_q    <= '0;
            snz_q    <= '0;
            missed_q <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            tmo_q    <= tmo_d;
            snz_q    <= snz_d;
            missed_q <= missed_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign Alarm        = Enable && (state_q == ST_ALARM);
    assign Snoozed      = Enable && (state_q == ST_SNOOZE);
    assign Alarm_Slot   = slot_q;
    assign Alarm_MedID  = (Enable && state_q != ST_IDLE) ? id_q : '1;
    assign Missed       = missed_q;
    assign Missed_Count = mcnt_q;
    assign Pending      = pend;

endmodule
